// File: rtl/trap_sequencer_if.sv
// Trap sequencer bundle: pipeline stage status in, trap request / flush controls out.
// The sequencer connects through modport master; the pipeline and CSR adapter side uses slave.
interface trap_sequencer_if #(
  parameter int XLEN = 32
);
  logic            id_v;
  logic            ex_v;
  logic            mem_v;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] mem_pc;
  logic            id_illegal;
  logic            id_ecall;
  logic            id_ebreak;
  logic            ex_misalign;
  logic            mem_ld_misalign;
  logic            mem_st_misalign;
  logic            intr_synced;
  logic            mstatus_mie;
  logic            mie_meie;
  logic            take_trap;
  logic            take_trap_raw;
  logic            trap_set;
  logic [31:0]     trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic            flush_id;
  logic            flush_ex;
  logic            flush_mem;
  logic            stall_if;
  logic            cu_intr_ack;
  logic            trap_busy;

  modport master (
    input  id_v, ex_v, mem_v, id_pc, ex_pc, mem_pc,
    input  id_illegal, id_ecall, id_ebreak, ex_misalign,
    input  mem_ld_misalign, mem_st_misalign,
    input  intr_synced, mstatus_mie, mie_meie, take_trap,
    output take_trap_raw, trap_set, trap_cause, trap_pc,
    output flush_id, flush_ex, flush_mem, stall_if, cu_intr_ack, trap_busy
  );

  modport slave (
    output id_v, ex_v, mem_v, id_pc, ex_pc, mem_pc,
    output id_illegal, id_ecall, id_ebreak, ex_misalign,
    output mem_ld_misalign, mem_st_misalign,
    output intr_synced, mstatus_mie, mie_meie, take_trap,
    input  take_trap_raw, trap_set, trap_cause, trap_pc,
    input  flush_id, flush_ex, flush_mem, stall_if, cu_intr_ack, trap_busy
  );
endinterface

// File: rtl/trap_sequencer.sv
// Trap arbiter / redirect sequencer: picks the oldest exception (or the external interrupt),
// raises the trap request, flushes, and holds fetch until redirect. Interrupts need TRAP_SEQ_IRQ_EN.
module trap_sequencer #(
  parameter int XLEN = 32
) (
  input logic              clk,
  input logic              rstn,
  trap_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [31:0] CAUSE_IRQ = 32'h8000_000B;

  state_t          state_q, state_d;
  logic [31:0]     cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic            irq_req;
  logic            win;
  logic            irq_win;
  logic [31:0]     win_cause;
  logic [XLEN-1:0] win_pc;
  logic [2:0]      win_flush;   // {mem, ex, id}

`ifdef TRAP_SEQ_IRQ_EN
  assign irq_req = bus.intr_synced & bus.mstatus_mie & bus.mie_meie & bus.id_v;
`else
  logic unused_irq;
  assign unused_irq = bus.intr_synced ^ bus.mstatus_mie ^ bus.mie_meie;
  assign irq_req    = 1'b0;
`endif

  // Oldest stage wins; losers are dropped and reappear on re-execution.
  always_comb begin
    win       = 1'b1;
    irq_win   = 1'b0;
    win_cause = '0;
    win_pc    = '0;
    win_flush = 3'b000;
    if (bus.mem_v & bus.mem_ld_misalign) begin
      win_cause = 32'd4;  win_pc = bus.mem_pc; win_flush = 3'b111;
    end else if (bus.mem_v & bus.mem_st_misalign) begin
      win_cause = 32'd6;  win_pc = bus.mem_pc; win_flush = 3'b111;
    end else if (bus.ex_v & bus.ex_misalign) begin
      win_cause = 32'd0;  win_pc = bus.ex_pc;  win_flush = 3'b011;
    end else if (bus.id_v & bus.id_illegal) begin
      win_cause = 32'd2;  win_pc = bus.id_pc;  win_flush = 3'b001;
    end else if (bus.id_v & bus.id_ebreak) begin
      win_cause = 32'd3;  win_pc = bus.id_pc;  win_flush = 3'b001;
    end else if (bus.id_v & bus.id_ecall) begin
      win_cause = 32'd11; win_pc = bus.id_pc;  win_flush = 3'b001;
    end else if (irq_req) begin
      win_cause = CAUSE_IRQ; win_pc = bus.id_pc; win_flush = 3'b001; irq_win = 1'b1;
    end else begin
      win = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cause_q <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE: begin
        if (win) begin
          cause_d = win_cause;
          pc_d    = win_pc;
          state_d = bus.take_trap ? ST_HOLD : ST_WAIT;
        end
      end
      ST_WAIT: if (bus.take_trap) state_d = ST_HOLD;
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low while rstn is asserted so a reset mid-trap clears them at once.
  always_comb begin
    bus.take_trap_raw = 1'b0;
    bus.trap_set      = 1'b0;
    bus.trap_cause    = '0;
    bus.trap_pc       = '0;
    bus.flush_id      = 1'b0;
    bus.flush_ex      = 1'b0;
    bus.flush_mem     = 1'b0;
    bus.stall_if      = 1'b0;
    bus.cu_intr_ack   = 1'b0;
    bus.trap_busy     = 1'b0;
    if (rstn) begin
      case (state_q)
        ST_IDLE: begin
          if (win) begin
            bus.take_trap_raw = 1'b1;
            bus.trap_set      = 1'b1;
            bus.trap_busy     = 1'b1;
            bus.stall_if      = 1'b1;
            bus.trap_cause    = win_cause;
            bus.trap_pc       = win_pc;
            bus.flush_id      = win_flush[0];
            bus.flush_ex      = win_flush[1];
            bus.flush_mem     = win_flush[2];
            bus.cu_intr_ack   = irq_win;
          end
        end
        ST_WAIT: begin
          bus.trap_busy  = 1'b1;
          bus.stall_if   = 1'b1;
          bus.flush_id   = 1'b1;
          bus.flush_ex   = 1'b1;
          bus.flush_mem  = 1'b1;
          bus.trap_cause = cause_q;
          bus.trap_pc    = pc_q;
        end
        ST_HOLD: bus.trap_busy = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed, table-driven bench for trap_sequencer: one record per cycle with hand-computed outputs,
// plus hand-written interrupt and reset-in-WAIT sequences.
module tb_trap_sequencer;

  logic clk;
  logic rstn;

  trap_sequencer_if #(.XLEN(32)) bus ();

  trap_sequencer #(.XLEN(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {raw, set, ack, stall, flush_mem, flush_ex, flush_id, busy}
  // fl  = {mem_st, mem_ld, ex_mis, ebreak, ecall, illegal}; v = {mem, ex, id}; irq = {intr, mie, meie}
  typedef struct {
    string       name;
    logic [2:0]  v;
    logic [31:0] id_pc;
    logic [31:0] ex_pc;
    logic [31:0] mem_pc;
    logic [5:0]  fl;
    logic [2:0]  irq;
    logic        tt;
    logic [7:0]  exp_ctl;
    logic [31:0] exp_cause;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(string n, logic [2:0] v, logic [31:0] ipc, logic [31:0] epc,
                              logic [31:0] mpc, logic [5:0] fl, logic [2:0] irq, logic tt,
                              logic [7:0] ctl, logic [31:0] c, logic [31:0] p);
    vec_t r;
    r.name = n; r.v = v; r.id_pc = ipc; r.ex_pc = epc; r.mem_pc = mpc;
    r.fl = fl; r.irq = irq; r.tt = tt; r.exp_ctl = ctl; r.exp_cause = c; r.exp_pc = p;
    return r;
  endfunction

  function automatic logic [7:0] dut_ctl();
    return {bus.take_trap_raw, bus.trap_set, bus.cu_intr_ack, bus.stall_if,
            bus.flush_mem, bus.flush_ex, bus.flush_id, bus.trap_busy};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    bus.id_v            = r.v[0];
    bus.ex_v            = r.v[1];
    bus.mem_v           = r.v[2];
    bus.id_pc           = r.id_pc;
    bus.ex_pc           = r.ex_pc;
    bus.mem_pc          = r.mem_pc;
    bus.id_illegal      = r.fl[0];
    bus.id_ecall        = r.fl[1];
    bus.id_ebreak       = r.fl[2];
    bus.ex_misalign     = r.fl[3];
    bus.mem_ld_misalign = r.fl[4];
    bus.mem_st_misalign = r.fl[5];
    bus.intr_synced     = r.irq[2];
    bus.mstatus_mie     = r.irq[1];
    bus.mie_meie        = r.irq[0];
    bus.take_trap       = r.tt;
  endtask

  // Drive on the falling edge, compare just before the next rising edge.
  task automatic run_vec(input vec_t r);
    @(negedge clk);
    drive(r);
    #2;
    $display("cycle %-14s ctl=%b cause=%h pc=%h", r.name, dut_ctl(), bus.trap_cause, bus.trap_pc);
    chk({r.name, ".ctl"},   {24'h0, dut_ctl()}, {24'h0, r.exp_ctl});
    chk({r.name, ".cause"}, bus.trap_cause, r.exp_cause);
    chk({r.name, ".pc"},    bus.trap_pc, r.exp_pc);
  endtask

  localparam logic [7:0] C_ZERO  = 8'b0000_0000;
  localparam logic [7:0] C_BUSY  = 8'b0000_0001;
  localparam logic [7:0] C_WAIT  = 8'b0001_1111;
  localparam logic [7:0] C_T_ID  = 8'b1101_0011;
  localparam logic [7:0] C_T_EX  = 8'b1101_0111;
  localparam logic [7:0] C_T_MEM = 8'b1101_1111;
  localparam logic [7:0] C_T_IRQ = 8'b1111_0011;
  localparam logic [31:0] IRQC   = 32'h8000_000B;

  vec_t idle;

  initial begin
    idle = mk("idle", 3'b000, 0, 0, 0, 6'b0, 3'b0, 1'b0, C_ZERO, 0, 0);
    rstn = 1'b0;
    drive(idle);

    tbl.push_back(mk("reset_idle",  3'b000, 0,      0,    0,      6'b000000, 3'b000, 0, C_ZERO,  0,  0));
    tbl.push_back(mk("ecall",       3'b001, 32'h100, 0,   0,      6'b000010, 3'b000, 1, C_T_ID,  11, 32'h100));
    tbl.push_back(mk("ecall_hold",  3'b001, 32'h100, 0,   0,      6'b000010, 3'b000, 0, C_BUSY,  0,  0));
    tbl.push_back(mk("idle1",       3'b000, 0,      0,    0,      6'b000000, 3'b000, 0, C_ZERO,  0,  0));
    tbl.push_back(mk("prio_ld",     3'b111, 32'h8,  32'h4, 32'h200, 6'b011001, 3'b000, 1, C_T_MEM, 4,  32'h200));
    tbl.push_back(mk("prio_hold",   3'b000, 0,      0,    0,      6'b000000, 3'b000, 0, C_BUSY,  0,  0));
    tbl.push_back(mk("prio_st",     3'b110, 0,      32'h8, 32'h204, 6'b101000, 3'b000, 1, C_T_MEM, 6,  32'h204));
    tbl.push_back(mk("st_hold",     3'b000, 0,      0,    0,      6'b000000, 3'b000, 0, C_BUSY,  0,  0));
    tbl.push_back(mk("ex_delay",    3'b010, 0,      32'h40, 0,    6'b001000, 3'b000, 0, C_T_EX,  0,  32'h40));
    tbl.push_back(mk("ex_wait1",    3'b000, 0,      0,    0,      6'b000000, 3'b000, 0, C_WAIT,  0,  32'h40));
    tbl.push_back(mk("ex_wait2",    3'b000, 0,      0,    0,      6'b000000, 3'b000, 1, C_WAIT,  0,  32'h40));
    tbl.push_back(mk("ex_hold",     3'b000, 0,      0,    0,      6'b000000, 3'b000, 0, C_BUSY,  0,  0));
    tbl.push_back(mk("idle2",       3'b000, 0,      0,    0,      6'b000000, 3'b000, 0, C_ZERO,  0,  0));
    tbl.push_back(mk("no_valid",    3'b000, 32'h9,  32'h9, 32'h9, 6'b111111, 3'b000, 1, C_ZERO,  0,  0));
    tbl.push_back(mk("ebrk_v_ecal", 3'b001, 32'h500, 0,   0,      6'b000110, 3'b000, 1, C_T_ID,  3,  32'h500));
    tbl.push_back(mk("hold_tt",     3'b000, 0,      0,    0,      6'b000000, 3'b000, 1, C_BUSY,  0,  0));
    tbl.push_back(mk("idle_tt",     3'b000, 0,      0,    0,      6'b000000, 3'b000, 1, C_ZERO,  0,  0));
    tbl.push_back(mk("illegal_dly", 3'b001, 32'h600, 0,   0,      6'b000001, 3'b000, 0, C_T_ID,  2,  32'h600));
    tbl.push_back(mk("ill_wait",    3'b000, 0,      0,    0,      6'b000000, 3'b000, 1, C_WAIT,  2,  32'h600));
    tbl.push_back(mk("ill_hold",    3'b000, 0,      0,    0,      6'b000000, 3'b000, 0, C_BUSY,  0,  0));
    tbl.push_back(mk("idle3",       3'b000, 0,      0,    0,      6'b000000, 3'b000, 0, C_ZERO,  0,  0));

    // Outputs must be zero under reset even with a request present.
    #3;
    bus.id_v = 1'b1; bus.id_ecall = 1'b1; bus.id_pc = 32'h44;
    #1;
    chk("in_reset.ctl", {24'h0, dut_ctl()}, 32'h0);
    drive(idle);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

`ifdef TRAP_SEQ_IRQ_EN
    run_vec(mk("irq",        3'b001, 32'h300, 0, 0, 6'b000000, 3'b111, 1, C_T_IRQ, IRQC, 32'h300));
    run_vec(mk("irq_hold",   3'b001, 32'h300, 0, 0, 6'b000000, 3'b111, 1, C_BUSY,  0,    0));
    run_vec(mk("irq_again",  3'b001, 32'h304, 0, 0, 6'b000000, 3'b111, 1, C_T_IRQ, IRQC, 32'h304));
    run_vec(mk("irq_hold2",  3'b000, 0,       0, 0, 6'b000000, 3'b000, 0, C_BUSY,  0,    0));
    run_vec(mk("irq_nomie",  3'b001, 32'h310, 0, 0, 6'b000000, 3'b101, 1, C_ZERO,  0,    0));
    run_vec(mk("irq_noidv",  3'b000, 32'h310, 0, 0, 6'b000000, 3'b111, 1, C_ZERO,  0,    0));
    run_vec(mk("ill_v_irq",  3'b001, 32'h340, 0, 0, 6'b000001, 3'b111, 1, C_T_ID,  2,    32'h340));
    run_vec(mk("ill_hold",   3'b001, 32'h344, 0, 0, 6'b000000, 3'b111, 0, C_BUSY,  0,    0));
    run_vec(mk("irq_after",  3'b001, 32'h344, 0, 0, 6'b000000, 3'b111, 1, C_T_IRQ, IRQC, 32'h344));
    run_vec(mk("irq_hold3",  3'b000, 0,       0, 0, 6'b000000, 3'b000, 0, C_BUSY,  0,    0));
`else
    run_vec(mk("irq_off",    3'b001, 32'h300, 0, 0, 6'b000000, 3'b111, 1, C_ZERO,  0,    0));
    run_vec(mk("ill_v_irq",  3'b001, 32'h340, 0, 0, 6'b000001, 3'b111, 1, C_T_ID,  2,    32'h340));
    run_vec(mk("ill_hold",   3'b001, 32'h344, 0, 0, 6'b000000, 3'b111, 0, C_BUSY,  0,    0));
    run_vec(mk("irq_off2",   3'b001, 32'h344, 0, 0, 6'b000000, 3'b111, 1, C_ZERO,  0,    0));
`endif

    // Reset while parked in WAIT: outputs clear at once and nothing is remembered.
    run_vec(mk("rst_ex",     3'b010, 0, 32'h80, 0, 6'b001000, 3'b000, 0, C_T_EX, 0, 32'h80));
    run_vec(mk("rst_wait",   3'b010, 0, 32'h80, 0, 6'b001000, 3'b000, 0, C_WAIT, 0, 32'h80));
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    $display("cycle %-14s ctl=%b cause=%h pc=%h", "rst_async", dut_ctl(), bus.trap_cause, bus.trap_pc);
    chk("rst_async.ctl",   {24'h0, dut_ctl()}, 32'h0);
    chk("rst_async.pc",    bus.trap_pc, 32'h0);
    drive(idle);
    @(negedge clk);
    rstn = 1'b1;
    run_vec(mk("post_rst1",  3'b000, 0, 0, 0, 6'b000000, 3'b000, 0, C_ZERO, 0, 0));
    run_vec(mk("post_rst2",  3'b000, 0, 0, 0, 6'b000000, 3'b000, 1, C_ZERO, 0, 0));
    run_vec(mk("post_ecall", 3'b001, 32'h700, 0, 0, 6'b000010, 3'b000, 0, C_T_ID, 11, 32'h700));
    run_vec(mk("post_wait",  3'b000, 0, 0, 0, 6'b000000, 3'b000, 1, C_WAIT, 11, 32'h700));
    run_vec(mk("post_hold",  3'b000, 0, 0, 0, 6'b000000, 3'b000, 0, C_BUSY, 0, 0));
    run_vec(mk("post_idle",  3'b000, 0, 0, 0, 6'b000000, 3'b000, 0, C_ZERO, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
